p5_writeback: RTL and testbench
===============================

# p5_writeback

Write-back stage of the SIMPLE five-stage pipeline, directly downstream of the memory-access stage. It takes the memory stage's result word, destination register and write flag, and commits them into the 8-entry, 16-bit general register file. It serves two combinational read ports to the decode stage and presents a registered commit record plus a retire counter for debug and trace.

## Interface
- DATA_W, 16, datapath and register width
- REG_N, 8, number of general registers; address width is clog2(REG_N) = 3

- clock  in  1  pipeline clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- WriteRegp4  in  1  commit request from memory stage
- RegAddressp4  in  3  destination register
- readOutData  in  DATA_W  result word (load data or ALU output)
- rdAddrA  in  3  decode read port A address
- rdAddrB  in  3  decode read port B address
- rdDataA  out  DATA_W  port A data, combinational
- rdDataB  out  DATA_W  port B data, combinational
- wbValid  out  1  registered; high for one cycle after each commit
- wbAddress  out  3  registered address of last commit
- wbData  out  DATA_W  registered data of last commit
- retireCount  out  16  registered count of commits, wraps

## Operation
- Commit: at posedge clock, with reset low and WriteRegp4 high, rf[RegAddressp4] <= readOutData. All 8 registers are writable; r0 is not hard-wired.
- WriteRegp4 low: no register changes, wbValid <= 0, and wbAddress/wbData hold.
- Commit record: on a commit, wbValid <= 1, wbAddress <= RegAddressp4, wbData <= readOutData.
- retireCount increments by 1 per commit, modulo 2^16. 0xFFFF + 1 -> 0x0000, with no flag.
- Read ports are independent. Both may address the same register, and both return identical data.
- Reset: rf[0..7], wbValid, wbAddress, wbData and retireCount all become 0. Reset takes priority over a coincident commit, so that write is dropped and not counted.
- Inputs are sampled only at posedge. The memory stage updates on negedge, so inputs are stable half a cycle before sampling.

## Timing
- Write latency: data committed at posedge N is visible on the read ports from posedge N onward, with no bypass required.
- With bypass: visible during cycle N itself (see Configuration).
- Commit record and retireCount reflect commit N at posedge N.
- Reset recovery: the first commit is accepted in the first cycle in which reset is low.
- There is no backpressure. Every cycle with WriteRegp4 high is a commit.

## Configuration
- P5_BYPASS_EN defined:
  - When WriteRegp4 = 1, reset = 0 and rdAddrX == RegAddressp4, rdDataX = readOutData, combinationally, before the edge.
  - Gives decode same-cycle forwarding of the writing instruction.
- Not defined:
  - rdDataX = rf[rdAddrX] only.
  - A register written at edge N reads the old value until edge N.

## Structure
- Package simple_pkg holds:
  - DATA_W and REG_ADDR_W constants.
  - word_t (logic [15:0]) and reg_addr_t (logic [2:0]) typedefs.
  - Shared with the decode and memory stages.
- Sub-module simple_regfile holds:
  - The register array with synchronous reset.
  - The write port and the two read muxes, including the bypass compare under P5_BYPASS_EN.
- p5_writeback holds the commit record registers and retireCount, and instantiates simple_regfile.

## Test plan
- Reset:
  - Stimulus: assert reset 2 cycles.
  - Response: all rdData = 0, wbValid = 0, retireCount = 0 for every address 0..7.
- Write/read:
  - Stimulus: commit r3 <= 0xBEEF, then rdAddrA = 3.
  - Response: rdDataA = 0xBEEF after the edge; wbValid = 1, wbAddress = 3, wbData = 0xBEEF for one cycle; retireCount = 1.
- Bypass:
  - Stimulus: r5 holds 0x1111; present commit r5 <= 0x2222 with rdAddrA = rdAddrB = 5; check before the edge.
  - Response with P5_BYPASS_EN: both ports = 0x2222.
  - Response without it: both ports = 0x1111.
- Write disabled:
  - Stimulus: WriteRegp4 = 0, RegAddressp4 = 2, readOutData = 0xFFFF.
  - Response: r2 unchanged, wbValid = 0, retireCount unchanged.
- Reset mid-operation:
  - Stimulus: commit r1 <= 0x00AA in the same cycle reset = 1.
  - Response: r1 = 0, retireCount = 0; the next-cycle commit is accepted normally.
- Wrap:
  - Stimulus: 65536 consecutive commits.
  - Response: retireCount returns to 0x0000; the last committed value is readable.

Source files
------------

// File: rtl/simple_pkg.sv
// ---------------------------------------------------------------------------
// simple_pkg
// Shared definitions for the SIMPLE five-stage pipeline (decode, memory and
// write-back stages all import this package).
//   DATA_W     : datapath / register width
//   REG_N      : number of general registers
//   REG_ADDR_W : register address width, clog2(REG_N)
//   word_t     : one datapath word
//   reg_addr_t : one register address
// ---------------------------------------------------------------------------
package simple_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_N      = 8;
    localparam int REG_ADDR_W = $clog2(REG_N);

    typedef logic [DATA_W-1:0]     word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : simple_pkg

// File: rtl/simple_regfile.sv
// ---------------------------------------------------------------------------
// simple_regfile
// 8 x 16-bit general register file: one synchronous write port and two
// independent combinational read ports. Every register, including r0, is
// writable. All registers clear on reset.
//
// Optional feature (macro P5_BYPASS_EN): when defined, a read port whose
// address matches the address being written this cycle returns the incoming
// write data combinationally (same-cycle forwarding). When undefined, reads
// return the stored register contents only.
//
// Ports:
//   clk     in   clock, all updates on posedge
//   srst    in   synchronous active-high reset
//   wr_en   in   write enable
//   wr_addr in   write address
//   wr_data in   write data
//   rd_addr_a / rd_addr_b in  read addresses
//   rd_data_a / rd_data_b out read data (combinational)
// ---------------------------------------------------------------------------
module simple_regfile
    import simple_pkg::*;
(
    input  logic      clk,
    input  logic      srst,
    input  logic      wr_en,
    input  reg_addr_t wr_addr,
    input  word_t     wr_data,
    input  reg_addr_t rd_addr_a,
    input  reg_addr_t rd_addr_b,
    output word_t     rd_data_a,
    output word_t     rd_data_b
);

    word_t rf_reg [REG_N];

    // Reset wins over a coincident write, so the write is simply dropped.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < REG_N; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (wr_en) begin
            rf_reg[wr_addr] <= wr_data;
        end
    end

`ifdef P5_BYPASS_EN
    // A write is only forwarded when it will actually commit at the edge,
    // i.e. not while reset is asserted.
    logic wr_live;
    assign wr_live = wr_en && !srst;

    always_comb begin
        rd_data_a = rf_reg[rd_addr_a];
        rd_data_b = rf_reg[rd_addr_b];
        if (wr_live && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
        if (wr_live && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
    end
`else
    always_comb begin
        rd_data_a = rf_reg[rd_addr_a];
        rd_data_b = rf_reg[rd_addr_b];
    end
`endif

endmodule : simple_regfile

// File: rtl/p5_writeback.sv
// ---------------------------------------------------------------------------
// p5_writeback
// Write-back stage of the SIMPLE pipeline. Commits the memory stage's result
// into the register file, serves two combinational read ports to decode and
// presents a registered commit record plus a wrapping retire counter.
//
// Optional feature (macro P5_BYPASS_EN): same-cycle forwarding of the value
// being committed onto the read ports (implemented in simple_regfile).
//
// Ports:
//   clock        in   pipeline clock
//   reset        in   synchronous, active-high
//   WriteRegp4   in   commit request from memory stage
//   RegAddressp4 in   destination register
//   readOutData  in   result word
//   rdAddrA/B    in   decode read addresses
//   rdDataA/B    out  read data, combinational
//   wbValid      out  high for one cycle after each commit
//   wbAddress    out  address of the last commit (holds when idle)
//   wbData       out  data of the last commit (holds when idle)
//   retireCount  out  number of commits, modulo 2^16
// ---------------------------------------------------------------------------
module p5_writeback
    import simple_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        WriteRegp4,
    input  reg_addr_t   RegAddressp4,
    input  word_t       readOutData,
    input  reg_addr_t   rdAddrA,
    input  reg_addr_t   rdAddrB,
    output word_t       rdDataA,
    output word_t       rdDataB,
    output logic        wbValid,
    output reg_addr_t   wbAddress,
    output word_t       wbData,
    output logic [15:0] retireCount
);

    logic        valid_reg;
    reg_addr_t   addr_reg;
    word_t       data_reg;
    logic [15:0] count_reg;

    simple_regfile u_regfile (
        .clk       (clock),
        .srst      (reset),
        .wr_en     (WriteRegp4),
        .wr_addr   (RegAddressp4),
        .wr_data   (readOutData),
        .rd_addr_a (rdAddrA),
        .rd_addr_b (rdAddrB),
        .rd_data_a (rdDataA),
        .rd_data_b (rdDataB)
    );

    // Commit record: address/data hold their last committed values while
    // idle; only the valid flag drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
            count_reg <= '0;
        end else begin
            valid_reg <= WriteRegp4;
            if (WriteRegp4) begin
                addr_reg  <= RegAddressp4;
                data_reg  <= readOutData;
                count_reg <= count_reg + 16'd1;   // wraps naturally
            end
        end
    end

    assign wbValid     = valid_reg;
    assign wbAddress   = addr_reg;
    assign wbData      = data_reg;
    assign retireCount = count_reg;

endmodule : p5_writeback

// File: tb/tb_p5_writeback.sv
// ---------------------------------------------------------------------------
// tb_p5_writeback
// Scoreboard bench for p5_writeback. The stimulus process drives inputs on
// the falling edge, checks the read ports before the rising edge against a
// behavioural register-file model, and queues the expected commit record.
// A separate monitor checks the commit record after every rising edge.
// Honours P5_BYPASS_EN in its read-port expectations.
// ---------------------------------------------------------------------------
module tb_p5_writeback;
    import simple_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        WriteRegp4 = 1'b0;
    reg_addr_t   RegAddressp4 = '0;
    word_t       readOutData = '0;
    reg_addr_t   rdAddrA = '0;
    reg_addr_t   rdAddrB = '0;
    word_t       rdDataA;
    word_t       rdDataB;
    logic        wbValid;
    reg_addr_t   wbAddress;
    word_t       wbData;
    logic [15:0] retireCount;

    p5_writeback dut (
        .clock        (clock),
        .reset        (reset),
        .WriteRegp4   (WriteRegp4),
        .RegAddressp4 (RegAddressp4),
        .readOutData  (readOutData),
        .rdAddrA      (rdAddrA),
        .rdAddrB      (rdAddrB),
        .rdDataA      (rdDataA),
        .rdDataB      (rdDataB),
        .wbValid      (wbValid),
        .wbAddress    (wbAddress),
        .wbData       (wbData),
        .retireCount  (retireCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
        logic [15:0] c;
    } rec_t;

    rec_t        exp_q[$];
    logic [15:0] rf_model [8];
    logic [15:0] count_model = 16'd0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected read data for the inputs currently applied, before the edge.
    function automatic logic [15:0] exp_read(input logic [2:0] ra);
`ifdef P5_BYPASS_EN
        if (WriteRegp4 && !reset && ra == RegAddressp4) return readOutData;
`endif
        return rf_model[ra];
    endfunction

    // One pipeline cycle: drive, check reads pre-edge, update model/scoreboard.
    task automatic cycle(input bit rst, input bit we, input logic [2:0] wa,
                         input logic [15:0] wd, input logic [2:0] ra,
                         input logic [2:0] rb, input bit verbose);
        @(negedge clock);
        reset        = rst;
        WriteRegp4   = we;
        RegAddressp4 = wa;
        readOutData  = wd;
        rdAddrA      = ra;
        rdAddrB      = rb;
        #1;
        chk("rdDataA", rdDataA, exp_read(ra));
        chk("rdDataB", rdDataB, exp_read(rb));
        if (verbose)
            $display("[TB] rst=%0b we=%0b r%0d<=%04h | A r%0d=%04h B r%0d=%04h",
                     rst, we, wa, wd, ra, rdDataA, rb, rdDataB);
        if (rst) begin
            for (int i = 0; i < 8; i++) rf_model[i] = 16'h0;
            count_model = 16'h0;
        end else if (we) begin
            rf_model[wa] = wd;
            count_model  = count_model + 16'd1;
            exp_q.push_back('{a: wa, d: wd, c: count_model});
        end
    endtask

    // Monitor: compares the registered commit record after each rising edge.
    initial begin
        rec_t        r;
        logic [2:0]  la = '0;
        logic [15:0] ld = '0;
        logic [15:0] lc = '0;
        bit          rs;
        forever begin
            @(posedge clock);
            rs = reset;
            #1;
            if (rs) begin
                exp_q.delete();
                chk("wbValid_rst", {31'b0, wbValid}, 32'd0);
                chk("wbAddress_rst", {29'b0, wbAddress}, 32'd0);
                chk("wbData_rst", {16'b0, wbData}, 32'd0);
                chk("retireCount_rst", {16'b0, retireCount}, 32'd0);
                la = '0; ld = '0; lc = '0;
            end else if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("wbValid", {31'b0, wbValid}, 32'd1);
                chk("wbAddress", {29'b0, wbAddress}, {29'b0, r.a});
                chk("wbData", {16'b0, wbData}, {16'b0, r.d});
                chk("retireCount", {16'b0, retireCount}, {16'b0, r.c});
                la = r.a; ld = r.d; lc = r.c;
            end else begin
                chk("wbValid_idle", {31'b0, wbValid}, 32'd0);
                chk("wbAddress_hold", {29'b0, wbAddress}, {29'b0, la});
                chk("wbData_hold", {16'b0, wbData}, {16'b0, ld});
                chk("retireCount_hold", {16'b0, retireCount}, {16'b0, lc});
            end
        end
    end

    initial begin
        logic [2:0]  wa;
        logic [15:0] wd;
        for (int i = 0; i < 8; i++) rf_model[i] = 16'h0;

        // Reset for two cycles, then sweep all addresses on both ports.
        cycle(1, 0, 3'd0, 16'h0, 3'd0, 3'd0, 1);
        cycle(1, 0, 3'd0, 16'h0, 3'd0, 3'd0, 1);
        for (int i = 0; i < 4; i++)
            cycle(0, 0, 3'(i), 16'h1234, 3'(i), 3'(i + 4), 1);

        // Write/read r3.
        cycle(0, 1, 3'd3, 16'hBEEF, 3'd0, 3'd1, 1);
        cycle(0, 0, 3'd0, 16'h0, 3'd3, 3'd3, 1);

        // Same-cycle read of a register being written.
        cycle(0, 1, 3'd5, 16'h1111, 3'd0, 3'd0, 1);
        cycle(0, 1, 3'd5, 16'h2222, 3'd5, 3'd5, 1);
        cycle(0, 0, 3'd0, 16'h0, 3'd5, 3'd5, 1);

        // Write disabled with live-looking data.
        cycle(0, 0, 3'd2, 16'hFFFF, 3'd2, 3'd2, 1);
        cycle(0, 0, 3'd2, 16'hFFFF, 3'd2, 3'd3, 1);

        // Reset coincident with a commit; next commit accepted normally.
        cycle(0, 1, 3'd1, 16'h0055, 3'd1, 3'd1, 1);
        cycle(1, 1, 3'd1, 16'h00AA, 3'd1, 3'd1, 1);
        cycle(0, 1, 3'd1, 16'h0077, 3'd1, 3'd3, 1);
        cycle(0, 0, 3'd0, 16'h0, 3'd1, 3'd3, 1);

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 31) == 0), 1'($urandom), 3'($urandom),
                  16'($urandom), 3'($urandom), 3'($urandom), 1);

        // Counter wrap: 65536 back-to-back commits from a clean reset.
        cycle(1, 0, 3'd0, 16'h0, 3'd0, 3'd0, 1);
        wa = '0; wd = '0;
        for (int i = 0; i < 65536; i++) begin
            wa = 3'($urandom);
            wd = 16'($urandom);
            cycle(0, 1, wa, wd, 3'($urandom), wa, 0);
        end
        $display("[TB] 65536 commits issued, last r%0d<=%04h", wa, wd);
        cycle(0, 0, 3'd0, 16'h0, wa, wa, 1);
        @(posedge clock);
        #2;
        chk("retireCount_wrap", {16'b0, retireCount}, 32'd0);
        chk("wrap_last_value", {16'b0, rdDataA}, {16'b0, wd});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_p5_writeback
